seq_recur_engine: RTL

//  Parametrised recurrence sequencer: reads two seed words from a synchronous RAM.

---
 rtl/seq_recur_pkg.sv | 22 ++
 rtl/seq_recur_engine_if.sv | 31 +++
 rtl/seq_alu.sv | 32 +++
 rtl/seq_recur_engine.sv | 119 +++++++++++
 4 files changed

// File: rtl/seq_recur_pkg.sv
// Shared encodings for the recurrence sequencer: operation modes and FSM states.
// No logic; types only.
// Imported by the ALU, the top and anything that decodes mode/state.
package seq_recur_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_XOR = 2'b10,
        MODE_AND = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LD0  = 3'd1,
        ST_LD1  = 3'd2,
        ST_LD2  = 3'd3,
        ST_COMP = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/seq_recur_engine_if.sv
// Bundle of control handshake, status and RAM port signals of the sequencer.
// Pure wiring, no latency.
// master = engine side, slave = host/RAM side.
interface seq_recur_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) ();
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [DATA_W-1:0] last;

    modport master (
        input  start, mode, base_addr, count, ram_rdata,
        output ram_raddr, ram_we, ram_waddr, ram_wdata, busy, done, ovf, last
    );

    modport slave (
        output start, mode, base_addr, count, ram_rdata,
        input  ram_raddr, ram_we, ram_waddr, ram_wdata, busy, done, ovf, last
    );
endinterface

// File: rtl/seq_alu.sv
// One recurrence step r = a OP b with an overflow indication.
// Purely combinational, zero latency.
// No flow control; consumer samples whenever it needs the result.
module seq_alu
    import seq_recur_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  mode_t             mode,
    output logic [DATA_W-1:0] r,
    output logic              ovf_bit
);

    // Select operation; only ADD carry and SUB borrow report overflow.
    always_comb begin
        r       = '0;
        ovf_bit = 1'b0;
        case (mode)
            MODE_ADD: {ovf_bit, r} = {1'b0, a} + {1'b0, b};
            MODE_SUB: begin
                r       = a - b;
                ovf_bit = (a < b);
            end
            MODE_XOR: r = a ^ b;
            MODE_AND: r = a & b;
            default:  r = '0;
        endcase
    end

endmodule

// File: rtl/seq_recur_engine.sv
// Loads two seeds from RAM, then writes count words x[n] = x[n-2] OP x[n-1].
// Latency: first write 4 cycles after start acceptance, done 4+count cycles after it.
// start is only taken in IDLE; requests while busy or in DONE are dropped.
module seq_recur_engine
    import seq_recur_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    seq_recur_engine_if.master bus
);

    state_t            state;
    mode_t             mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] k_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              ovf_q;
    logic [DATA_W-1:0] last_q;

    logic [DATA_W-1:0] alu_r;
    logic              alu_ovf;

    logic [ADDR_W-1:0] raddr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .a       (a_q),
        .b       (b_q),
        .mode    (mode_q),
        .r       (alu_r),
        .ovf_bit (alu_ovf)
    );

    // Sequencer FSM plus the two-word window, step counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_ADD;
            base_q  <= '0;
            count_q <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ovf_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q  <= mode_t'(bus.mode);
                        base_q  <= bus.base_addr;
                        count_q <= bus.count;
                        ovf_q   <= 1'b0;
                        state   <= ST_LD0;
                    end
                end
                ST_LD0: state <= ST_LD1;
                ST_LD1: begin
                    a_q   <= bus.ram_rdata;
                    state <= ST_LD2;
                end
                ST_LD2: begin
                    b_q   <= bus.ram_rdata;
                    k_q   <= '0;
                    state <= (count_q != '0) ? ST_COMP : ST_DONE;
                end
                ST_COMP: begin
                    a_q    <= b_q;
                    b_q    <= alu_r;
                    last_q <= alu_r;
                    ovf_q  <= ovf_q | alu_ovf;
                    k_q    <= k_q + ADDR_W'(1);
                    if (k_q == count_q - ADDR_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM addressing and write strobe decoded from state; a reset in a write
    // cycle suppresses that write so an abort never commits a partial step.
    always_comb begin
        raddr = '0;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (state)
            ST_LD0: raddr = base_q;
            ST_LD1: raddr = base_q + ADDR_W'(1);
            ST_COMP: begin
                we    = ~rst;
                waddr = base_q + ADDR_W'(2) + k_q;
                wdata = alu_r;
            end
            default: ;
        endcase
    end

    assign bus.ram_raddr = raddr;
    assign bus.ram_we    = we;
    assign bus.ram_waddr = waddr;
    assign bus.ram_wdata = wdata;
    assign bus.busy      = (state == ST_LD0) || (state == ST_LD1) ||
                           (state == ST_LD2) || (state == ST_COMP);
    assign bus.done      = (state == ST_DONE);
    assign bus.ovf       = ovf_q;
    assign bus.last      = last_q;

endmodule
